// File: rtl/spike_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_event_encoder
//  Purpose  : Turns ON/OFF spikes from a delta modulator into time-stamped
//             event words {polarity, sat, dt} and queues them in a FIFO.
//             A saturating delta timer measures the cycles since the last
//             accepted event. Events that arrive while the FIFO is full and
//             nothing is leaving are dropped and counted.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             on_spike_i           - ON spike pulse (wins over OFF)
//             off_spike_i          - OFF spike pulse
//             evt_valid_o          - FIFO head holds an event
//             evt_ready_i          - downstream accepts the head event
//             evt_data_o           - head event word {polarity, sat, dt}
//             count_o              - current FIFO occupancy
//             drop_o               - pulse, one cycle after a dropped event
//             drop_cnt_o           - saturating dropped-event count
//  Revision : 1.0  initial release
// ============================================================================
module spike_event_encoder #(
  parameter int DEPTH = 8,
  parameter int DT_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       on_spike_i,
  input  logic                       off_spike_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [DT_W+1:0]            evt_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = $clog2(DEPTH) + 1;
  localparam int C_EW = DT_W + 2;

  localparam logic [C_CW-1:0] C_FULL    = C_CW'(DEPTH);
  localparam logic [C_CW-1:0] C_CNT_ONE = C_CW'(1);
  localparam logic [C_AW-1:0] C_PTR_ONE = C_AW'(1);
  localparam logic [DT_W-1:0] C_DT_ONE  = DT_W'(1);
  localparam logic [DT_W-1:0] C_DT_MAX  = '1;
  localparam logic [7:0]      C_DCNT_MAX = 8'hFF;

  // State
  logic [C_EW-1:0] mem_q [DEPTH];
  logic [C_EW-1:0] mem_d [DEPTH];
  logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_CW-1:0] count_q, count_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic            drop_q, drop_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  // Per-cycle decisions
  logic            evt;
  logic            pop;
  logic            push;
  logic            drop;
  logic            dt_sat;
  logic [C_EW-1:0] evt_word;

  always_comb begin
    evt      = on_spike_i | off_spike_i;
    pop      = (count_q != '0) & evt_ready_i;
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    push     = evt & ((count_q != C_FULL) | pop);
    drop     = evt & ~push;
    dt_sat   = (dt_cnt_q == C_DT_MAX);
    // ON has priority when both spikes coincide; the OFF is simply lost.
    evt_word = {on_spike_i, dt_sat, dt_cnt_q};
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dt_cnt_d   = dt_cnt_q;
    drop_d     = drop;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = evt_word;
      wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    // Timer restarts at 1 on an accepted event, otherwise saturates upward.
    // A dropped event does not restart it.
    if (push) begin
      dt_cnt_d = C_DT_ONE;
    end else if (!dt_sat) begin
      dt_cnt_d = dt_cnt_q + C_DT_ONE;
    end

    if (drop && (drop_cnt_q != C_DCNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dt_cnt_q   <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dt_cnt_q   <= dt_cnt_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head is read straight from storage; new events only become visible
  // after they have been written.
  assign evt_valid_o = (count_q != '0);
  assign evt_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign drop_o      = drop_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spike_event_encoder
//  Purpose  : Self-checking bench for spike_event_encoder. A queue-based
//             reference model predicts every output each cycle; directed
//             scenarios add literal expectations; a random phase follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spike_event_encoder;

  localparam int DEPTH  = 8;
  localparam int DT_W   = 6;
  localparam int EW     = DT_W + 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int DT_MAX = (1 << DT_W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          on_spike_i = 1'b0;
  logic          off_spike_i = 1'b0;
  logic          evt_ready_i = 1'b0;
  logic          evt_valid_o;
  logic [EW-1:0] evt_data_o;
  logic [CW-1:0] count_o;
  logic          drop_o;
  logic [7:0]    drop_cnt_o;

  spike_event_encoder #(.DEPTH(DEPTH), .DT_W(DT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .on_spike_i  (on_spike_i),
    .off_spike_i (off_spike_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_data_o  (evt_data_o),
    .count_o     (count_o),
    .drop_o      (drop_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] m_q[$];
  int            m_dt   = 0;
  bit            m_drop = 1'b0;
  int            m_dcnt = 0;
  bit            armed  = 1'b0;
  bit            m_ev, m_pop, m_room;
  int            m_word;

  always @(negedge clk) begin
    if (armed) begin
      chk("evt_valid", evt_valid_o, m_q.size() != 0);
      chk("count", count_o, m_q.size());
      chk("drop_o", drop_o, m_drop);
      chk("drop_cnt", drop_cnt_o, m_dcnt);
      chk("data_known", $isunknown(evt_data_o), 0);
      if (m_q.size() != 0) chk("evt_data", evt_data_o, m_q[0]);
    end
    if (rst) begin
      m_q.delete();
      m_dt   = 0;
      m_drop = 0;
      m_dcnt = 0;
      armed  = 1'b1;
    end else begin
      m_ev   = on_spike_i || off_spike_i;
      m_pop  = (m_q.size() > 0) && evt_ready_i;
      m_room = (m_q.size() < DEPTH) || m_pop;
      m_word = (int'(on_spike_i) << (DT_W + 1)) + ((m_dt == DT_MAX) ? (1 << DT_W) : 0) + m_dt;
      if (m_pop) void'(m_q.pop_front());
      m_drop = m_ev && !m_room;
      if (m_ev && m_room) begin
        m_q.push_back(EW'(m_word));
        m_dt = 1;
      end else begin
        m_dt = (m_dt + 1 > DT_MAX) ? DT_MAX : m_dt + 1;
      end
      if (m_drop && m_dcnt < 255) m_dcnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Apply inputs for one cycle; returns 1 time unit after the next rising edge.
  task automatic cyc(input bit on, input bit off, input bit rdy);
    on_spike_i  = on;
    off_spike_i = off;
    evt_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, rdy);
  endtask

  int pulses;

  initial begin
    @(posedge clk);
    #1;

    // Reset state and first-event dt / latency.
    do_reset();
    chk("rst_count", count_o, 0);
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_dropcnt", drop_cnt_o, 0);
    chk("rst_data", evt_data_o, 0);
    idle(5, 0);
    cyc(1, 0, 0);
    chk("c6_valid", evt_valid_o, 1);
    chk("c6_data", evt_data_o, 8'h85);
    chk("c6_count", count_o, 1);

    // ON/OFF/ON+OFF ordering and pop order.
    do_reset();
    idle(10, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    idle(7, 0);
    chk("ord_count", count_o, 3);
    chk("ord_w0", evt_data_o, 8'h8A);
    cyc(0, 0, 1);
    chk("ord_w1", evt_data_o, 8'h01);
    cyc(0, 0, 1);
    chk("ord_w2", evt_data_o, 8'h81);
    cyc(0, 0, 1);
    chk("ord_empty", evt_valid_o, 0);
    chk("ord_nodrop", drop_cnt_o, 0);

    // Timer saturation then a short gap.
    do_reset();
    idle(100, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("sat_w0", evt_data_o, 8'h7F);
    cyc(0, 0, 1);
    chk("sat_w1", evt_data_o, 8'h03);
    cyc(0, 0, 1);

    // Overflow: 10 ON spikes into an 8-deep FIFO.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0);
      pulses += int'(drop_o);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0);
      pulses += int'(drop_o);
    end
    chk("ovf_count", count_o, 8);
    chk("ovf_pulses", pulses, 2);
    chk("ovf_dropcnt", drop_cnt_o, 2);
    chk("ovf_head", evt_data_o, 8'h80);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) chk("ovf_drain", evt_data_o, 8'h81);
      cyc(0, 0, 1);
    end
    chk("ovf_empty", evt_valid_o, 0);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0);
    cyc(1, 0, 1);
    chk("fpp_count", count_o, 8);
    chk("fpp_drop", drop_o, 0);
    chk("fpp_head", evt_data_o, 8'h81);
    idle(8, 1);

    // Reset mid-operation during a pop with a spike present.
    do_reset();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 1);
    rst = 1'b0;
    chk("mid_count", count_o, 0);
    chk("mid_valid", evt_valid_o, 0);
    chk("mid_dropcnt", drop_cnt_o, 0);
    idle(4, 0);
    cyc(1, 0, 0);
    chk("mid_dt", evt_data_o, 8'h84);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 270; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("dcnt_sat", drop_cnt_o, 255);
    chk("dcnt_full", count_o, 8);

    // Randomised traffic with occasional resets.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct = $urandom_range(10, 95);
      int spk_pct = $urandom_range(5, 90);
      for (int i = 0; i < 200; i++) begin
        rst = ($urandom_range(0, 399) == 0);
        cyc($urandom_range(0, 99) < spk_pct, $urandom_range(0, 99) < spk_pct,
            $urandom_range(0, 99) < rdy_pct);
      end
    end
    rst = 1'b0;
    idle(20, 1);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_event_encoder.md
SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning event FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DT_W, default 6, meaning width of the delta-time field.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port on_spike_i  input  1  ON spike from the upstream delta modulator, one-cycle pulse.
REQ-006 Port off_spike_i  input  1  OFF spike from the upstream delta modulator, one-cycle pulse.
REQ-007 Port evt_valid_o  output  1  FIFO head holds an event.
REQ-008 Port evt_ready_i  input  1  downstream accepts the head event.
REQ-009 Port evt_data_o  output  DT_W+2  event word: {polarity, sat, dt}.
REQ-010 Port count_o  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 Port drop_o  output  1  one-cycle pulse, one cycle after an event is dropped.
REQ-012 Port drop_cnt_o  output  8  saturating count of dropped events.

Function
REQ-013 The block SHALL keep a delta timer dt_cnt (DT_W bits) that, in every cycle without a push, becomes min(dt_cnt+1, 2^DT_W-1).
REQ-014 A spike event SHALL exist in any cycle where on_spike_i or off_spike_i is 1; if both are 1, it SHALL be one ON event, with the OFF spike discarded and not counted as a drop.
REQ-015 On an event, the pushed word SHALL be polarity=1 for ON or 0 for OFF, sat=1 if dt_cnt equals 2^DT_W-1 else 0, and dt=dt_cnt as of that cycle.
REQ-016 A push SHALL occur when an event exists and either count_o<DEPTH or a pop occurs in the same cycle.
REQ-017 On a push, dt_cnt SHALL load 1, so consecutive-cycle events record dt=1.
REQ-018 An event arriving while count_o==DEPTH with no same-cycle pop SHALL be dropped.
REQ-019 On a drop, the FIFO contents SHALL be left unchanged.
REQ-020 On a drop, dt_cnt SHALL keep counting per REQ-013 and SHALL NOT be reset.
REQ-021 On a drop, drop_o SHALL be 1 in the next cycle.
REQ-022 On a drop, drop_cnt_o SHALL increment, saturating at 255.
REQ-023 A pop SHALL occur when evt_valid_o and evt_ready_i are both 1; it SHALL remove the head entry.
REQ-024 evt_ready_i while empty SHALL have no effect.
REQ-025 evt_valid_o SHALL equal (count_o != 0), and evt_data_o SHALL present the head entry combinationally from FIFO storage.
REQ-026 A pushed event SHALL first appear on evt_valid_o/evt_data_o in the cycle after the push (latency 1), including when the FIFO was empty; there SHALL be no input-to-output bypass.
REQ-027 A simultaneous push and pop SHALL leave count_o unchanged, including at count_o==DEPTH and count_o==1.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; event order SHALL be strictly FIFO.
REQ-029 While evt_valid_o=1 and evt_ready_i=0, evt_data_o SHALL hold stable.
REQ-030 evt_data_o SHALL be don't-care while evt_valid_o=0, but SHALL contain no X after reset.

Reset
REQ-031 While rst=1 at a rising edge, the FIFO SHALL become empty: count_o=0 and evt_valid_o=0.
REQ-032 While rst=1 at a rising edge, dt_cnt SHALL become 0, and drop_o and drop_cnt_o SHALL become 0.
REQ-033 While rst=1 at a rising edge, pointers SHALL become 0, and storage SHALL become 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued events, and spikes present in reset cycles SHALL be ignored.
REQ-035 After rst falls, the first event at cycle k (k=0 being the first non-reset cycle) SHALL record dt=min(k, 2^DT_W-1).

Verification
REQ-036 Reset, hold evt_ready_i=0, ON at cycle 5 -> cycle 6: evt_valid_o=1, evt_data_o={1,0,5}, count_o=1.
REQ-037 ON at cycle 10, OFF at cycle 11, ON+OFF at cycle 12, ready=1 from cycle 20 -> pops in order {1,0,10}, {0,0,1}, {1,0,1}; no drop.
REQ-038 No spikes for 100 cycles then OFF -> word {0,1,63}; next OFF 3 cycles later -> {0,0,3}.
REQ-039 Ready=0, 10 ON spikes on consecutive cycles with DEPTH=8 -> count_o=8, two drop_o pulses, drop_cnt_o=2, and the first 8 events drain unchanged.
REQ-040 FIFO full, ready=1, and ON in the same cycle -> push accepted, count_o stays 8, drop_o stays 0.
REQ-041 Three events queued, assert rst for 1 cycle during a pop with a spike present -> count_o=0, evt_valid_o=0, drop_cnt_o=0, and the next event's dt counts from reset release.
